// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset default and entry layout for the fetch unit and its
// instruction buffer.
package fetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and decode handshake bundle of the fetch unit.
interface fetch_unit_if;

  logic [fetch_unit_pkg::XLEN-1:0] IMEM_ADDR;
  logic [fetch_unit_pkg::XLEN-1:0] IMEM_DATA;
  logic                            REDIRECT;
  logic [fetch_unit_pkg::XLEN-1:0] REDIRECT_PC;
  logic                            ID_READY;
  logic                            IR_VALID;
  logic [fetch_unit_pkg::XLEN-1:0] IR;
  logic [fetch_unit_pkg::XLEN-1:0] IR_PC;

  modport master (
    output IMEM_ADDR, IR_VALID, IR, IR_PC,
    input  IMEM_DATA, REDIRECT, REDIRECT_PC, ID_READY
  );

  modport slave (
    input  IMEM_ADDR, IR_VALID, IR, IR_PC,
    output IMEM_DATA, REDIRECT, REDIRECT_PC, ID_READY
  );

endinterface

// File: rtl/fetch_buf.sv
// DEPTH x 64-bit instruction FIFO; head entry and valid flag are registered so
// decode sees flop outputs only.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_r, rd_r, wr_s, rd_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  fetch_entry_t     head_r, head_s;
  logic             valid_r;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign pop_ok_s  = pop && (cnt_r != {CNT_W{1'b0}}) && !clear;
  assign push_ok_s = push && ((cnt_r < DEPTH_C) || pop_ok_s) && !clear;

  // Next pointers/count, and the entry that will sit at the head after the edge.
  always_comb begin
    wr_s   = wr_r;
    rd_s   = rd_r;
    cnt_s  = cnt_r;
    head_s = EMPTY_ENTRY;
    if (clear) begin
      wr_s  = {PTR_W{1'b0}};
      rd_s  = {PTR_W{1'b0}};
      cnt_s = {CNT_W{1'b0}};
    end else begin
      wr_s = push_ok_s ? ptr_inc(wr_r) : wr_r;
      rd_s = pop_ok_s ? ptr_inc(rd_r) : rd_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: cnt_s = cnt_r;
      endcase
    end
    // The new entry lands at the head only when nothing older survives the edge.
    if (cnt_s == {CNT_W{1'b0}}) begin
      head_s = EMPTY_ENTRY;
    end else if (push_ok_s && (wr_r == rd_s)) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_s];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= EMPTY_ENTRY;
      wr_r    <= {PTR_W{1'b0}};
      rd_r    <= {PTR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      head_r  <= EMPTY_ENTRY;
      valid_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_r] <= din;
      end else begin
        mem_r[wr_r] <= mem_r[wr_r];
      end
      wr_r    <= wr_s;
      rd_r    <= rd_s;
      cnt_r   <= cnt_s;
      head_r  <= head_s;
      valid_r <= (cnt_s != {CNT_W{1'b0}});
    end
  end

  assign dout  = head_r;
  assign valid = valid_r;
  assign count = cnt_r;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect and a small decoupling buffer
// toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST_X,
  fetch_unit_if.master  bus
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] count_s;
  logic             valid_s;
  logic             pop_s, fetch_s;
  fetch_entry_t     push_entry_s, head_s;

  // A redirect flushes the buffer and blocks both push and pop for that edge.
  assign pop_s        = valid_s && bus.ID_READY && !bus.REDIRECT;
  assign fetch_s      = !bus.REDIRECT && ((count_s < DEPTH_C) || pop_s);
  assign push_entry_s = '{pc: pc_r, instr: bus.IMEM_DATA};

  // Program counter: redirect target, sequential step, or hold.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      pc_r <= RESET_PC;
    end else if (bus.REDIRECT) begin
      pc_r <= {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
    end else if (fetch_s) begin
      pc_r <= pc_step(pc_r);
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (CLK),
    .rst_n (RST_X),
    .clear (bus.REDIRECT),
    .push  (fetch_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .valid (valid_s),
    .count (count_s)
  );

  assign bus.IMEM_ADDR = pc_r;
  assign bus.IR_VALID  = valid_s;
  assign bus.IR        = head_s.instr;
  assign bus.IR_PC     = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based model of
// the fetch/decode handshake.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST_X;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] q [$];
  logic [31:0] m_pc;

  fetch_unit_if bif ();

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bif)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a < 32'd20) return 32'h11 * (a / 32'd4 + 32'd1);
    else            return a ^ 32'hDEAD_BEEF;
  endfunction

  assign bif.IMEM_DATA = mem_f(bif.IMEM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_ir, e_pc;
    e_ir = (q.size() != 0) ? q[0][31:0]  : 32'h0;
    e_pc = (q.size() != 0) ? q[0][63:32] : 32'h0;
    chk({tag, ".ir_valid"}, {31'h0, bif.IR_VALID}, {31'h0, q.size() != 0});
    chk({tag, ".ir"},       bif.IR,    e_ir);
    chk({tag, ".ir_pc"},    bif.IR_PC, e_pc);
    chk({tag, ".imem_addr"}, bif.IMEM_ADDR, m_pc);
    chk({tag, ".count"}, 32'(dut.u_buf.count), 32'(q.size()));
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = RPC;
  endtask

  // One clock: drive inputs, advance the model, then sample after the edge.
  task automatic step(input string tag, input logic redir, input logic [31:0] rpc, input logic rdy);
    bit pop_m, fetch_m;
    bif.REDIRECT    = redir;
    bif.REDIRECT_PC = rpc;
    bif.ID_READY    = rdy;
    pop_m = (q.size() != 0) && rdy;
    if (redir) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      fetch_m = (q.size() < DEPTH) || pop_m;
      if (pop_m) void'(q.pop_front());
      if (fetch_m) begin
        q.push_back({m_pc, mem_f(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge CLK);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    model_reset();
    @(posedge CLK);
    #3;
    RST_X = 1'b1;
  endtask

  initial begin
    RST_X = 1'b0;
    bif.REDIRECT = 1'b0;
    bif.REDIRECT_PC = 32'h0;
    bif.ID_READY = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    RST_X = 1'b1;

    // Streaming from reset: IR_PC 0..16, IR 11..55.
    for (int i = 0; i < 5; i++) begin
      step("stream", 1'b0, 32'h0, 1'b1);
      chk("stream.pc_const", bif.IR_PC, 32'(i * 4));
      chk("stream.ir_const", bif.IR, 32'h11 * 32'(i + 1));
    end

    // Decode stall fills the buffer and freezes PC.
    do_reset();
    for (int i = 0; i < 5; i++) step("stall", 1'b0, 32'h0, 1'b0);
    chk("stall.pc_hold", bif.IMEM_ADDR, 32'h8);
    chk("stall.ir_hold", bif.IR, 32'h11);
    step("resume0", 1'b0, 32'h0, 1'b1);
    chk("resume0.pc", bif.IR_PC, 32'h4);
    step("resume1", 1'b0, 32'h0, 1'b1);
    chk("resume1.pc", bif.IR_PC, 32'h8);
    chk("full_pushpop.count", 32'(dut.u_buf.count), 32'd2);

    // Redirect with a full buffer and ready decode.
    for (int i = 0; i < 3; i++) step("fill", 1'b0, 32'h0, 1'b0);
    step("redir", 1'b1, 32'h103, 1'b1);
    chk("redir.bubble", {31'h0, bif.IR_VALID}, 32'h0);
    step("redir_tgt", 1'b0, 32'h0, 1'b1);
    chk("redir_tgt.pc", bif.IR_PC, 32'h100);

    // Back-to-back redirects: last wins.
    step("b2b0", 1'b1, 32'h200, 1'b1);
    step("b2b1", 1'b1, 32'h301, 1'b1);
    step("b2b2", 1'b0, 32'h0, 1'b1);
    chk("b2b.pc", bif.IR_PC, 32'h300);

    // PC wrap at the top of the address space.
    step("wrap_r", 1'b1, 32'hFFFF_FFFC, 1'b1);
    step("wrap0", 1'b0, 32'h0, 1'b1);
    chk("wrap0.pc", bif.IR_PC, 32'hFFFF_FFFC);
    step("wrap1", 1'b0, 32'h0, 1'b1);
    chk("wrap1.pc", bif.IR_PC, 32'h0);

    // Asynchronous reset mid-operation with a full buffer.
    for (int i = 0; i < 3; i++) step("prefill", 1'b0, 32'h0, 1'b0);
    #2;
    RST_X = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    chk("async_rst.ir", bif.IR, 32'h0);
    @(posedge CLK);
    #3;
    RST_X = 1'b1;
    step("restart", 1'b0, 32'h0, 1'b1);
    chk("restart.pc", bif.IR_PC, RPC);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic        r, y;
      logic [31:0] t;
      r = ($urandom_range(0, 7) == 0);
      y = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 31));
      step("rand", r, t, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
